alu_param: RTL and testbench

- Next-generation ALU, parametrised in operand width.
- Adds an operand-collection FSM: A and B may arrive in different cycles, with a timeout.
- Adds a two-stage pipelined multiply, plus explicit res_valid/busy handshake outputs.
- Sits in the same datapath slot as the current 8-bit ALU; the self-checking stimulus-file bench drives it.

---
 rtl/alu_param_pkg.sv | 61 ++++++
 rtl/alu_param_core.sv | 139 +++++++++++++
 rtl/alu_param.sv | 252 +++++++++++++++++++++++++
 tb/tb_alu_param.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_param_pkg.sv
// Shared definitions for the parametrised ALU: command codes for both modes,
// FSM state encoding and the operand-requirement lookup.
package alu_param_pkg;

  // Arithmetic-mode command codes (mode = 1)
  localparam logic [3:0] ARI_ADD     = 4'd0;
  localparam logic [3:0] ARI_SUB     = 4'd1;
  localparam logic [3:0] ARI_ADD_CIN = 4'd2;
  localparam logic [3:0] ARI_SUB_CIN = 4'd3;
  localparam logic [3:0] ARI_INC_A   = 4'd4;
  localparam logic [3:0] ARI_DEC_A   = 4'd5;
  localparam logic [3:0] ARI_INC_B   = 4'd6;
  localparam logic [3:0] ARI_DEC_B   = 4'd7;
  localparam logic [3:0] ARI_CMP     = 4'd8;
  localparam logic [3:0] ARI_MUL_INC = 4'd9;
  localparam logic [3:0] ARI_MUL_SHL = 4'd10;

  // Logic-mode command codes (mode = 0)
  localparam logic [3:0] LOG_AND    = 4'd0;
  localparam logic [3:0] LOG_NAND   = 4'd1;
  localparam logic [3:0] LOG_OR     = 4'd2;
  localparam logic [3:0] LOG_NOR    = 4'd3;
  localparam logic [3:0] LOG_XOR    = 4'd4;
  localparam logic [3:0] LOG_XNOR   = 4'd5;
  localparam logic [3:0] LOG_NOT_A  = 4'd6;
  localparam logic [3:0] LOG_NOT_B  = 4'd7;
  localparam logic [3:0] LOG_SHR1_A = 4'd8;
  localparam logic [3:0] LOG_SHL1_A = 4'd9;
  localparam logic [3:0] LOG_SHR1_B = 4'd10;
  localparam logic [3:0] LOG_SHL1_B = 4'd11;
  localparam logic [3:0] LOG_ROL    = 4'd12;
  localparam logic [3:0] LOG_ROR    = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_OP = 2'd1,
    ST_MUL     = 2'd2
  } state_e;

  // Returns {need_b, need_a}. Illegal codes report "both" so they follow the
  // normal collection path and are flagged at capture time.
  function automatic logic [1:0] op_req(input logic mode, input logic [3:0] cmd);
    logic [1:0] req;
    req = 2'b11;
    if (mode) begin
      case (cmd)
        ARI_INC_A, ARI_DEC_A: req = 2'b01;
        ARI_INC_B, ARI_DEC_B: req = 2'b10;
        default:              req = 2'b11;
      endcase
    end else begin
      case (cmd)
        LOG_NOT_A, LOG_SHR1_A, LOG_SHL1_A: req = 2'b01;
        LOG_NOT_B, LOG_SHR1_B, LOG_SHL1_B: req = 2'b10;
        default:                           req = 2'b11;
      endcase
    end
    return req;
  endfunction

endpackage

// File: rtl/alu_param_core.sv
// Combinational ALU datapath. Produces the single-cycle result and flags, or
// for multiply commands the two pre-conditioned multiplicands that the top
// registers as pipeline stage 1.
module alu_param_core
  import alu_param_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               mode,
  input  logic [3:0]         cmd,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  output logic [2*WIDTH-1:0] res,
  output logic               cout,
  output logic               oflow,
  output logic               g,
  output logic               e,
  output logic               l,
  output logic               err,
  output logic               illegal,
  output logic               mul_op,
  output logic [WIDTH:0]     mul_x,
  output logic [WIDTH:0]     mul_y
);

  localparam int W   = WIDTH;
  localparam int SHW = $clog2(WIDTH);
  localparam logic [W-1:0] ONE_W  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_W1 = {{W{1'b0}}, 1'b1};

  logic [W:0]     sum_w;
  logic [W-1:0]   diff_w;
  logic [2*W-1:0] rot_w;
  logic [SHW-1:0] amt;

  assign amt = b[SHW-1:0];

  // Decode the command and compute the result and the flags it defines
  always_comb begin
    res     = '0;
    cout    = 1'b0;
    oflow   = 1'b0;
    g       = 1'b0;
    e       = 1'b0;
    l       = 1'b0;
    err     = 1'b0;
    illegal = 1'b0;
    mul_op  = 1'b0;
    mul_x   = '0;
    mul_y   = '0;
    sum_w   = '0;
    diff_w  = '0;
    rot_w   = '0;
    if (mode) begin
      case (cmd)
        ARI_ADD, ARI_ADD_CIN: begin
          sum_w = {1'b0, a} + {1'b0, b} + ((cmd == ARI_ADD_CIN) ? {{W{1'b0}}, cin} : '0);
          res   = {{(W-1){1'b0}}, sum_w};
          cout  = sum_w[W];
        end
        ARI_SUB: begin
          diff_w = a - b;
          res    = {{W{1'b0}}, diff_w};
          oflow  = (a < b);
        end
        ARI_SUB_CIN: begin
          diff_w = a - b - {{(W-1){1'b0}}, cin};
          res    = {{W{1'b0}}, diff_w};
          oflow  = ({1'b0, a} < ({1'b0, b} + {{W{1'b0}}, cin}));
        end
        ARI_INC_A: begin
          diff_w = a + ONE_W;
          res    = {{W{1'b0}}, diff_w};
          oflow  = (a == '1);
        end
        ARI_DEC_A: begin
          diff_w = a - ONE_W;
          res    = {{W{1'b0}}, diff_w};
          oflow  = (a == '0);
        end
        ARI_INC_B: begin
          diff_w = b + ONE_W;
          res    = {{W{1'b0}}, diff_w};
          oflow  = (b == '1);
        end
        ARI_DEC_B: begin
          diff_w = b - ONE_W;
          res    = {{W{1'b0}}, diff_w};
          oflow  = (b == '0);
        end
        ARI_CMP: begin
          g = (a > b);
          e = (a == b);
          l = (a < b);
        end
        ARI_MUL_INC: begin
          mul_op = 1'b1;
          mul_x  = {1'b0, a} + ONE_W1;
          mul_y  = {1'b0, b} + ONE_W1;
        end
        ARI_MUL_SHL: begin
          mul_op = 1'b1;
          mul_x  = {a, 1'b0};
          mul_y  = {1'b0, b};
        end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (cmd)
        LOG_AND:    res = {{W{1'b0}}, a & b};
        LOG_NAND:   res = {{W{1'b0}}, ~(a & b)};
        LOG_OR:     res = {{W{1'b0}}, a | b};
        LOG_NOR:    res = {{W{1'b0}}, ~(a | b)};
        LOG_XOR:    res = {{W{1'b0}}, a ^ b};
        LOG_XNOR:   res = {{W{1'b0}}, ~(a ^ b)};
        LOG_NOT_A:  res = {{W{1'b0}}, ~a};
        LOG_NOT_B:  res = {{W{1'b0}}, ~b};
        LOG_SHR1_A: res = {{W{1'b0}}, a >> 1};
        LOG_SHL1_A: res = {{W{1'b0}}, a << 1};
        LOG_SHR1_B: res = {{W{1'b0}}, b >> 1};
        LOG_SHL1_B: res = {{W{1'b0}}, b << 1};
        LOG_ROL: begin
          // Rotating a doubled copy keeps the wrapped bits in the upper half
          rot_w = {a, a} << amt;
          res   = {{W{1'b0}}, rot_w[2*W-1:W]};
          err   = |(b >> SHW);
        end
        LOG_ROR: begin
          rot_w = {a, a} >> amt;
          res   = {{W{1'b0}}, rot_w[W-1:0]};
          err   = |(b >> SHW);
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_param.sv
// Parametrised ALU top: operand-collection FSM with timeout, two-stage
// multiply and registered outputs with a res_valid pulse.
// Handshake: res_valid is high for exactly one enabled cycle after every
// output update; busy is high while a command is in flight (WAIT_OP or MUL),
// and during that time new commands are not accepted. ce=0 freezes all state.
module alu_param
  import alu_param_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               mode,
  input  logic [3:0]         cmd,
  input  logic [1:0]         inp_valid,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               cin,
  output logic [2*WIDTH-1:0] res,
  output logic               cout,
  output logic               oflow,
  output logic               g,
  output logic               e,
  output logic               l,
  output logic               err,
  output logic               res_valid,
  output logic               busy,
  output logic [1:0]         state_dbg
);

  localparam int W   = WIDTH;
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [3:0]     cmd_q, cmd_d;
  logic           mode_q, mode_d, cin_q, cin_d;
  logic [1:0]     miss_q, miss_d;
  logic [W:0]     mx_q, mx_d, my_q, my_d;
  logic [2*W-1:0] res_q, res_d;
  logic           cout_q, cout_d, oflow_q, oflow_d;
  logic           g_q, g_d, e_q, e_d, l_q, l_d;
  logic           err_q, err_d, rv_q, rv_d;

  logic           c_mode, c_cin;
  logic [3:0]     c_cmd;
  logic [W-1:0]   c_a, c_b;
  logic [2*W-1:0] c_res;
  logic           c_cout, c_oflow, c_g, c_e, c_l, c_err, c_illegal, c_mul;
  logic [W:0]     c_mx, c_my;
  logic [2*W-1:0] prod_w;
  logic [1:0]     req, miss;
  logic           capture, err_ev;

  // Core sees live inputs in IDLE, the latched command plus the newly
  // arriving operand in WAIT_OP
  always_comb begin
    c_mode = mode;
    c_cmd  = cmd;
    c_cin  = cin;
    c_a    = opa;
    c_b    = opb;
    if (state_q == ST_WAIT_OP) begin
      c_mode = mode_q;
      c_cmd  = cmd_q;
      c_cin  = cin_q;
      c_a    = miss_q[0] ? opa : a_q;
      c_b    = miss_q[1] ? opb : b_q;
    end
  end

  alu_param_core #(.WIDTH(WIDTH)) u_core (
    .mode    (c_mode),
    .cmd     (c_cmd),
    .a       (c_a),
    .b       (c_b),
    .cin     (c_cin),
    .res     (c_res),
    .cout    (c_cout),
    .oflow   (c_oflow),
    .g       (c_g),
    .e       (c_e),
    .l       (c_l),
    .err     (c_err),
    .illegal (c_illegal),
    .mul_op  (c_mul),
    .mul_x   (c_mx),
    .mul_y   (c_my)
  );

  // Multiply stage 2: full product of the registered multiplicands
  assign prod_w = {{(W-1){1'b0}}, mx_q} * {{(W-1){1'b0}}, my_q};

  // Next-state, operand collection, timeout and output update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cmd_d   = cmd_q;
    mode_d  = mode_q;
    cin_d   = cin_q;
    miss_d  = miss_q;
    mx_d    = mx_q;
    my_d    = my_q;
    res_d   = res_q;
    cout_d  = cout_q;
    oflow_d = oflow_q;
    g_d     = g_q;
    e_d     = e_q;
    l_d     = l_q;
    err_d   = err_q;
    rv_d    = rv_q;
    req     = op_req(mode, cmd);
    miss    = req & ~inp_valid;
    capture = 1'b0;
    err_ev  = 1'b0;
    if (ce) begin
      rv_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (inp_valid == 2'b00) begin
            err_ev = 1'b1;
          end else if (miss == 2'b00) begin
            capture = 1'b1;
          end else begin
            if (inp_valid[0]) a_d = opa;
            if (inp_valid[1]) b_d = opb;
            cmd_d   = cmd;
            mode_d  = mode;
            cin_d   = cin;
            miss_d  = miss;
            cnt_d   = '0;
            state_d = ST_WAIT_OP;
          end
        end
        ST_WAIT_OP: begin
          if ((inp_valid & miss_q) == miss_q) begin
            capture = 1'b1;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            err_ev = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_MUL: begin
          res_d   = prod_w;
          cout_d  = 1'b0;
          oflow_d = 1'b0;
          g_d     = 1'b0;
          e_d     = 1'b0;
          l_d     = 1'b0;
          err_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (capture) begin
        state_d = ST_IDLE;
        if (c_illegal) begin
          err_ev = 1'b1;
        end else if (c_mul) begin
          mx_d    = c_mx;
          my_d    = c_my;
          state_d = ST_MUL;
        end else begin
          res_d   = c_res;
          cout_d  = c_cout;
          oflow_d = c_oflow;
          g_d     = c_g;
          e_d     = c_e;
          l_d     = c_l;
          err_d   = c_err;
          rv_d    = 1'b1;
        end
      end

      // Error update: result held, all other flags cleared
      if (err_ev) begin
        cout_d  = 1'b0;
        oflow_d = 1'b0;
        g_d     = 1'b0;
        e_d     = 1'b0;
        l_d     = 1'b0;
        err_d   = 1'b1;
        rv_d    = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // State, latched operands and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      miss_q  <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      oflow_q <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
      l_q     <= 1'b0;
      err_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmd_q   <= cmd_d;
      mode_q  <= mode_d;
      cin_q   <= cin_d;
      miss_q  <= miss_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      oflow_q <= oflow_d;
      g_q     <= g_d;
      e_q     <= e_d;
      l_q     <= l_d;
      err_q   <= err_d;
      rv_q    <= rv_d;
    end
  end

  assign res       = res_q;
  assign cout      = cout_q;
  assign oflow     = oflow_q;
  assign g         = g_q;
  assign e         = e_q;
  assign l         = l_q;
  assign err       = err_q;
  assign res_valid = rv_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_alu_param.sv
// Directed bench for alu_param (WIDTH=8, TIMEOUT=16) with hand-computed
// expected results.
module tb_alu_param;

  localparam int W = 8;

  logic           clk, rst, ce, mode, cin;
  logic [3:0]     cmd;
  logic [1:0]     inp_valid;
  logic [W-1:0]   opa, opb;
  logic [2*W-1:0] res;
  logic           cout, oflow, g, e, l, err, res_valid, busy;
  logic [1:0]     state_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [2*W-1:0] exp_q[$];

  alu_param #(.WIDTH(W), .TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .mode      (mode),
    .cmd       (cmd),
    .inp_valid (inp_valid),
    .opa       (opa),
    .opb       (opb),
    .cin       (cin),
    .res       (res),
    .cout      (cout),
    .oflow     (oflow),
    .g         (g),
    .e         (e),
    .l         (l),
    .err       (err),
    .res_valid (res_valid),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pops the next expected result from the scoreboard and compares res
  task automatic check_res(input string tag);
    logic [2*W-1:0] exp;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check(tag, {16'h0, res}, {16'h0, exp});
    end
  endtask

  task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] iv,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    mode = m; cmd = c; inp_valid = iv; opa = a; opb = b; cin = ci;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags are packed {cout, oflow, g, e, l, err}
  function automatic logic [31:0] flags();
    return {26'h0, cout, oflow, g, e, l, err};
  endfunction

  // One-edge command: apply, then check result, flags and res_valid
  task automatic apply(input string tag, input logic m, input logic [3:0] c,
                       input logic [1:0] iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input logic [2*W-1:0] exp_res, input logic [5:0] exp_fl);
    drive(m, c, iv, a, b, ci);
    tick();
    exp_q.push_back(exp_res);
    check_res({tag, "_res"});
    check({tag, "_flags"}, flags(), {26'h0, exp_fl});
    check({tag, "_rv"}, {31'h0, res_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b0; ce = 1'b1;
    drive(1'b0, 4'd0, 2'b00, '0, '0, 1'b0);
    #12;
    check("rst_res", {16'h0, res}, 32'h0);
    check("rst_flags", flags(), 32'h0);
    check("rst_rv", {31'h0, res_valid}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_state", {30'h0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Idle edge with no operands is an error update
    tick();
    check("idle_err", flags(), 32'h01);
    check("idle_rv", {31'h0, res_valid}, 32'd1);

    // Single-cycle arithmetic and logic vectors
    apply("add",     1'b1, 4'd0,  2'b11, 8'hFF, 8'h01, 1'b0, 16'h0100, 6'b100000);
    apply("add_cin", 1'b1, 4'd2,  2'b11, 8'h01, 8'h02, 1'b1, 16'h0004, 6'b000000);
    apply("sub",     1'b1, 4'd1,  2'b11, 8'h03, 8'h05, 1'b0, 16'h00FE, 6'b010000);
    apply("sub_cin", 1'b1, 4'd3,  2'b11, 8'h05, 8'h04, 1'b1, 16'h0000, 6'b000000);
    apply("dec_a",   1'b1, 4'd5,  2'b01, 8'h00, 8'h33, 1'b0, 16'h00FF, 6'b010000);
    apply("inc_b",   1'b1, 4'd6,  2'b10, 8'h44, 8'hFF, 1'b0, 16'h0000, 6'b010000);
    apply("xor",     1'b0, 4'd4,  2'b11, 8'hF0, 8'hFF, 1'b0, 16'h000F, 6'b000000);
    apply("not_b",   1'b0, 4'd7,  2'b10, 8'h00, 8'h3C, 1'b0, 16'h00C3, 6'b000000);
    apply("shl1_a",  1'b0, 4'd9,  2'b01, 8'h81, 8'h00, 1'b0, 16'h0002, 6'b000000);
    apply("cmp_lt",  1'b1, 4'd8,  2'b11, 8'h10, 8'h20, 1'b0, 16'h0000, 6'b000010);
    apply("cmp_eq",  1'b1, 4'd8,  2'b11, 8'h20, 8'h20, 1'b0, 16'h0000, 6'b000100);
    apply("rol",     1'b0, 4'd12, 2'b11, 8'h81, 8'h01, 1'b0, 16'h0003, 6'b000000);
    apply("rol_big", 1'b0, 4'd12, 2'b11, 8'h81, 8'h09, 1'b0, 16'h0003, 6'b000001);
    apply("ror",     1'b0, 4'd13, 2'b11, 8'h81, 8'h02, 1'b0, 16'h0060, 6'b000000);
    apply("ill_log", 1'b0, 4'd14, 2'b11, 8'h12, 8'h34, 1'b0, 16'h0060, 6'b000001);
    apply("ill_ari", 1'b1, 4'd11, 2'b11, 8'h12, 8'h34, 1'b0, 16'h0060, 6'b000001);

    // Multiply (A+1)*(B+1); the command offered while busy must be ignored
    drive(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0);
    tick();
    check("mul_busy", {31'h0, busy}, 32'd1);
    check("mul_state", {30'h0, state_dbg}, 32'd2);
    check("mul_rv0", {31'h0, res_valid}, 32'd0);
    drive(1'b1, 4'd0, 2'b11, 8'd1, 8'd1, 1'b0);
    tick();
    exp_q.push_back(16'h0014);
    check_res("mul_inc_res");
    check("mul_inc_rv", {31'h0, res_valid}, 32'd1);
    check("mul_inc_busy", {31'h0, busy}, 32'd0);
    check("mul_inc_flags", flags(), 32'h0);

    // (A<<1)*B with A's MSB set, and the product wrap boundary
    drive(1'b1, 4'd10, 2'b11, 8'h80, 8'h03, 1'b0);
    tick();
    drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    exp_q.push_back(16'h0300);
    check_res("mul_shl_res");
    drive(1'b1, 4'd9, 2'b11, 8'hFF, 8'hFF, 1'b0);
    tick();
    drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    exp_q.push_back(16'h0000);
    check_res("mul_wrap_res");
    check("mul_wrap_rv", {31'h0, res_valid}, 32'd1);

    // Split operands: A now, B three idle cycles later
    drive(1'b1, 4'd0, 2'b01, 8'd5, 8'h00, 1'b0);
    tick();
    check("split_busy0", {31'h0, busy}, 32'd1);
    check("split_rv0", {31'h0, res_valid}, 32'd0);
    drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("split_busy", {31'h0, busy}, 32'd1);
    end
    drive(1'b0, 4'd4, 2'b10, 8'hAA, 8'd7, 1'b0);
    tick();
    exp_q.push_back(16'h000C);
    check_res("split_res");
    check("split_rv", {31'h0, res_valid}, 32'd1);
    check("split_busy_end", {31'h0, busy}, 32'd0);
    check("split_flags", flags(), 32'h0);

    // Timeout after 16 edges with no B
    drive(1'b1, 4'd1, 2'b01, 8'd9, 8'h00, 1'b0);
    tick();
    drive(1'b1, 4'd1, 2'b00, 8'h00, 8'h00, 1'b0);
    for (int i = 1; i <= 15; i++) tick();
    check("to_busy15", {31'h0, busy}, 32'd1);
    check("to_rv15", {31'h0, res_valid}, 32'd0);
    tick();
    exp_q.push_back(16'h000C);
    check_res("to_res");
    check("to_flags", flags(), 32'h01);
    check("to_rv", {31'h0, res_valid}, 32'd1);
    check("to_busy", {31'h0, busy}, 32'd0);

    // Reset in the middle of WAIT_OP
    drive(1'b1, 4'd0, 2'b01, 8'd1, 8'h00, 1'b0);
    tick();
    drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("mrst_res", {16'h0, res}, 32'h0);
    check("mrst_flags", flags(), 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'd0);
    check("mrst_rv", {31'h0, res_valid}, 32'd0);
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("mrst_rv_after", {31'h0, res_valid}, 32'd0);
    check("mrst_state", {30'h0, state_dbg}, 32'd0);

    // ce=0 for 5 edges during WAIT_OP delays the timeout by 5 edges
    ce = 1'b1;
    drive(1'b1, 4'd0, 2'b01, 8'd2, 8'h00, 1'b0);
    tick();
    drive(1'b1, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
    for (int k = 1; k <= 21; k++) begin
      ce = (k >= 6 && k <= 10) ? 1'b0 : 1'b1;
      tick();
      if (k == 16) begin
        check("ce_busy16", {31'h0, busy}, 32'd1);
        check("ce_rv16", {31'h0, res_valid}, 32'd0);
      end
      if (k == 20) check("ce_busy20", {31'h0, busy}, 32'd1);
      if (k == 21) begin
        check("ce_rv21", {31'h0, res_valid}, 32'd1);
        check("ce_flags21", flags(), 32'h01);
        check("ce_busy21", {31'h0, busy}, 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
